// File: rtl/arb4_rr.sv
// arb4_rr: four-way round-robin arbiter for one shared 4:1 single-bit mux.
// Requesters hold req[i] until served; gnt is one-hot, sel drives the mux
// select, busy flags an active grant. All outputs come from flops.
//
// Optional build macro ARB4_HOLD_LIMIT_EN: caps a single owner at MAX_HOLD
// consecutive grant cycles whenever another requester is waiting. Without it,
// an owner keeps the grant for as long as it holds its request.
//
// state | meaning
// IDLE  | no grant, busy=0, gnt=0, sel holds last owner
// GRANT | one requester owns the mux, busy=1, gnt one-hot on sel
module arb4_rr #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_d;
  logic [3:0] gnt_d;

  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       own_req;
  logic       hold_expire;
  logic       hand_off;

  // First set bit of r scanning start, start+1, ... mod 4; {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT gnt is the owner's one-hot, so this masks out the current owner.
  assign others    = req & ~gnt;
  assign own_req   = req[sel];
  assign pick_idle = rr_pick(req, ptr_q);
  // The released owner sits last in the new order, so it is served after everyone else.
  assign pick_next = rr_pick(others, sel + 2'd1);

`ifdef ARB4_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  assign hold_expire = own_req && (hold_q == HOLD_LAST) && (|others);

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end

  // Clear on owner change or at the limit with nobody waiting, else count up.
  always_comb begin
    hold_d = 8'd0;
    if (state_q == GRANT && !hand_off) begin
      if (hold_q == HOLD_LAST) hold_d = 8'd0;
      else                     hold_d = hold_q + 8'd1;
    end
  end
`else
  logic unused_max_hold;

  assign unused_max_hold = ^MAX_HOLD;
  assign hold_expire     = 1'b0;
`endif

  assign hand_off = (state_q == GRANT) && (!own_req || hold_expire);

  // State and registered outputs; reset lands in IDLE with requester 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_idle[2]) state_d = GRANT;
      GRANT:   if (hand_off && !pick_next[2]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next grant, select and priority pointer; sel only moves with a new owner.
  always_comb begin
    gnt_d = gnt;
    sel_d = sel;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          sel_d = pick_idle[1:0];
          gnt_d = 4'b0001 << pick_idle[1:0];
        end
      end
      GRANT: begin
        if (hand_off) begin
          ptr_d = sel + 2'd1;
          if (pick_next[2]) begin
            sel_d = pick_next[1:0];
            gnt_d = 4'b0001 << pick_next[1:0];
          end else begin
            gnt_d = 4'b0000;
          end
        end
      end
      default: gnt_d = 4'b0000;
    endcase
  end

  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: directed stimulus for arb4_rr with a queue-based scoreboard fed
// by a small reference model of the round-robin rules, plus fixed-value
// spot checks at the interesting points.
module tb_arb4_rr;

  localparam int TB_MAXH = 4;
`ifdef ARB4_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  logic [3:0] mux_in = 4'b1101;
  logic       mux_out;
  assign mux_out = mux_in[sel];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       mux;
  } exp_t;

  exp_t sb[$];

  bit         m_busy;
  logic [1:0] m_owner;
  logic [1:0] m_ptr;
  int         m_hold;

  arb4_rr #(.MAX_HOLD(TB_MAXH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 2'd0;
    m_ptr   = 2'd0;
    m_hold  = 0;
  endtask

  function automatic int first_from(input logic [3:0] r, input logic [1:0] start);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (int'(start) + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    int nxt;
    logic [3:0] rest;
    if (!m_busy) begin
      nxt = first_from(r, m_ptr);
      if (nxt >= 0) begin
        m_busy  = 1'b1;
        m_owner = 2'(nxt);
        m_hold  = 0;
      end
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner] || (HOLD_EN && m_hold == TB_MAXH - 1 && rest != 4'b0000)) begin
        m_ptr = m_owner + 2'd1;
        nxt   = first_from(rest, m_ptr);
        m_hold = 0;
        if (nxt >= 0) m_owner = 2'(nxt);
        else          m_busy  = 1'b0;
      end else if (HOLD_EN) begin
        m_hold = (m_hold == TB_MAXH - 1) ? 0 : m_hold + 1;
      end
    end
  endtask

  // Drive one cycle of req, predict, then compare just after the edge.
  task automatic cyc(input logic [3:0] r, input string tag);
    exp_t e;
    req = r;
    model_step(r);
    e.gnt  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.sel  = m_owner;
    e.busy = m_busy;
    e.mux  = mux_in[m_owner];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".gnt"},    8'(gnt),  8'(e.gnt));
    check({tag, ".sel"},    8'(sel),  8'(e.sel));
    check({tag, ".busy"},   8'(busy), 8'(e.busy));
    check({tag, ".onehot"}, 8'($countones(gnt) <= 1), 8'd1);
    if (e.busy) check({tag, ".mux"}, 8'(mux_out), 8'(e.mux));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    check({tag, ".rst_gnt"},  8'(gnt),  8'h00);
    check({tag, ".rst_sel"},  8'(sel),  8'h00);
    check({tag, ".rst_busy"}, 8'(busy), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] drop;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #12;
    check("por.gnt",  8'(gnt),  8'h00);
    check("por.sel",  8'(sel),  8'h00);
    check("por.busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester held five cycles, then idle
    repeat (5) cyc(4'b0001, "s1");
    cyc(4'b0000, "s1");
    cyc(4'b0000, "s1");
    check("s1.idle_busy", 8'(busy), 8'h00);

    // all four requesting, each owner drops after three grant cycles
    do_reset("s2");
    cyc(4'b1111, "s2");
    for (int o = 0; o < 4; o++) begin
      cyc(4'b1111, "s2");
      cyc(4'b1111, "s2");
      drop = 4'b1111;
      drop[o] = 1'b0;
      cyc(drop, "s2");
    end
    check("s2.wrap_sel", 8'(sel), 8'h00);
    check("s2.wrap_gnt", 8'(gnt), 8'h01);

    // ptr=3 after owner 2 releases; 3 before 0, then wrap to 0
    do_reset("s3");
    cyc(4'b0100, "s3");
    cyc(4'b0100, "s3");
    cyc(4'b1001, "s3");
    check("s3.gnt3", 8'(gnt), 8'h08);
    check("s3.sel3", 8'(sel), 8'h03);
    cyc(4'b1001, "s3");
    cyc(4'b0001, "s3");
    check("s3.gnt0", 8'(gnt), 8'h01);

    // two requesters held continuously
    do_reset("s4");
    repeat (14) cyc(4'b0011, "s4");
`ifdef ARB4_HOLD_LIMIT_EN
    check("s4.final", 8'(gnt), 8'h02);
`else
    check("s4.final", 8'(gnt), 8'h01);
`endif

    // async reset in the middle of requester 2's grant
    do_reset("s5");
    repeat (3) cyc(4'b0100, "s5");
    #3;
    rst_n = 1'b0;
    #1;
    check("s5.async_gnt",  8'(gnt),  8'h00);
    check("s5.async_sel",  8'(sel),  8'h00);
    check("s5.async_busy", 8'(busy), 8'h00);
    model_reset();
    #2;
    rst_n = 1'b1;
    cyc(4'b0100, "s5");
    check("s5.first_gnt", 8'(gnt), 8'h04);

    // mux path: in0..in3 = 1,0,1,1
    do_reset("s6");
    cyc(4'b1010, "s6");
    check("s6.mux1", 8'(mux_out), 8'h00);
    cyc(4'b1010, "s6");
    cyc(4'b1010, "s6");
    cyc(4'b1000, "s6");
    check("s6.mux3", 8'(mux_out), 8'h01);
    cyc(4'b1000, "s6");
    cyc(4'b0000, "s6");

    // released owner re-requesting goes behind the others
    do_reset("s7");
    cyc(4'b0011, "s7");
    cyc(4'b0110, "s7");
    cyc(4'b0101, "s7");
    check("s7.skip_owner", 8'(gnt), 8'h04);
    cyc(4'b0001, "s7");
    check("s7.late0", 8'(gnt), 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
